// File: rtl/n64adv_vdemux_gen_pkg.sv
// Shared constants and types for the N64 VD bus demultiplexer and its mode detector.
package n64adv_vdemux_pkg;

  localparam int unsigned SYNC_VSYNC = 3;
  localparam int unsigned SYNC_CLAMP = 2;
  localparam int unsigned SYNC_HSYNC = 1;
  localparam int unsigned SYNC_CSYNC = 0;

  localparam int unsigned DEF_COLOR_W    = 7;
  localparam int unsigned DEF_NUM_CH     = 3;
  localparam int unsigned DEF_LINE_W     = 10;
  localparam int unsigned DEF_PAL_THRESH = 300;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_CAPT = 2'd1,
    PH_OVER = 2'd2
  } ph_state_e;

  typedef enum logic [1:0] {
    FH_NONE = 2'd0,
    FH_ONE  = 2'd1,
    FH_CMP  = 2'd2
  } fld_hist_e;

  typedef enum logic {
    STD_NTSC = 1'b0,
    STD_PAL  = 1'b1
  } video_std_e;

  typedef enum logic {
    SCAN_PROGRESSIVE = 1'b0,
    SCAN_INTERLACED  = 1'b1
  } scan_mode_e;

  function automatic logic fell(input logic prev, input logic curr);
    return prev & ~curr;
  endfunction

endpackage

// File: rtl/n64adv_vdemux_gen_if.sv
// VD pad bus in and demultiplexed pixel bus out of the video input stage.
interface n64adv_vdemux_gen_if #(
  parameter int unsigned COLOR_W = 7,
  parameter int unsigned NUM_CH  = 3
) ();
  logic                      nVDSYNC;
  logic [COLOR_W-1:0]        VD_i;
  logic                      vdata_valid;
  logic [3:0]                vdata_sync;
  logic [NUM_CH*COLOR_W-1:0] vdata_col;

  modport master (
    output nVDSYNC, VD_i,
    input  vdata_valid, vdata_sync, vdata_col
  );

  modport slave (
    input  nVDSYNC, VD_i,
    output vdata_valid, vdata_sync, vdata_col
  );
endinterface

// File: rtl/n64adv_vdemux_gen_vmode_detect.sv
// Line counting per field, PAL/NTSC decision and 240p/480i detection with
// two-field hysteresis, driven by each new demultiplexed pixel's sync bits.
module n64adv_vmode_detect
  import n64adv_vdemux_pkg::*;
#(
  parameter int unsigned LINE_W     = DEF_LINE_W,
  parameter int unsigned PAL_THRESH = DEF_PAL_THRESH
) (
  input  logic              VCLK,
  input  logic              nVRST,
  input  logic              i_valid,
  input  logic              i_nvsync,
  input  logic              i_nhsync,
  output logic [LINE_W-1:0] o_lines_field,
  output logic              o_is_pal,
  output logic              o_is_480i,
  output logic              o_field_id
);

  logic              r_prev_vs;
  logic              r_prev_hs;
  logic [LINE_W-1:0] r_line_cnt;
  logic [LINE_W-1:0] r_lines_field;
  logic              r_field_id;
  logic              r_last_diff;
  fld_hist_e         r_hist;
  video_std_e        r_std;
  scan_mode_e        r_scan;

  logic w_vs_fall;
  logic w_hs_fall;
  logic w_diff;

  always_comb begin
    w_vs_fall = i_valid & fell(r_prev_vs, i_nvsync);
    w_hs_fall = i_valid & fell(r_prev_hs, i_nhsync);
    w_diff    = i_nhsync ^ r_field_id;
  end

  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      r_prev_vs     <= 1'b1;
      r_prev_hs     <= 1'b1;
      r_line_cnt    <= '0;
      r_lines_field <= '0;
      r_field_id    <= 1'b0;
      r_last_diff   <= 1'b0;
      r_hist        <= FH_NONE;
      r_std         <= STD_NTSC;
      r_scan        <= SCAN_PROGRESSIVE;
    end else if (i_valid) begin
      r_prev_vs <= i_nvsync;
      r_prev_hs <= i_nhsync;
      // A vsync fall takes priority, so a coincident hsync fall is not counted.
      if (w_vs_fall) begin
        r_lines_field <= r_line_cnt;
        r_line_cnt    <= '0;
        r_field_id    <= i_nhsync;
        r_std         <= (r_line_cnt > LINE_W'(PAL_THRESH)) ? STD_PAL : STD_NTSC;
        case (r_hist)
          FH_NONE: r_hist <= FH_ONE;
          FH_ONE: begin
            r_last_diff <= w_diff;
            r_hist      <= FH_CMP;
          end
          default: begin
            r_last_diff <= w_diff;
            if (w_diff == r_last_diff)
              r_scan <= w_diff ? SCAN_INTERLACED : SCAN_PROGRESSIVE;
          end
        endcase
      end else if (w_hs_fall && (r_line_cnt != '1)) begin
        r_line_cnt <= r_line_cnt + LINE_W'(1);
      end
    end
  end

  always_comb begin
    o_lines_field = r_lines_field;
    o_is_pal      = (r_std == STD_PAL);
    o_is_480i     = (r_scan == SCAN_INTERLACED);
    o_field_id    = r_field_id;
  end

endmodule

// File: rtl/n64adv_vdemux_gen.sv
// N64 VD bus demultiplexer: one sync phase plus NUM_CH colour phases per pixel,
// framing check, and PAL/NTSC / 240p-480i detection on the completed pixels.
module n64adv_vdemux_gen
  import n64adv_vdemux_pkg::*;
#(
  parameter int unsigned COLOR_W    = DEF_COLOR_W,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned LINE_W     = DEF_LINE_W,
  parameter int unsigned PAL_THRESH = DEF_PAL_THRESH
) (
  input  logic                VCLK,
  input  logic                nVRST,
  n64adv_vdemux_gen_if.slave  vbus,
  output logic                phase_err,
  output logic [LINE_W-1:0]   lines_field,
  output logic                is_pal,
  output logic                is_480i,
  output logic                field_id
);

  localparam int unsigned PH_W = $clog2(NUM_CH + 1);

  ph_state_e                 r_state;
  ph_state_e                 w_state_nxt;
  logic [PH_W-1:0]           r_ph;
  logic [3:0]                r_sync_sh;
  logic [COLOR_W-1:0]        r_ch_sh [NUM_CH];
  logic                      r_done;
  logic                      r_valid;
  logic                      r_phase_err;
  logic [3:0]                r_sync_out;
  logic [NUM_CH*COLOR_W-1:0] r_col_out;

  logic                      w_nsync;
  logic [COLOR_W-1:0]        w_vd;
  logic                      w_cap_sync;
  logic                      w_cap_ch;
  logic                      w_last_ch;
  logic                      w_err;
  logic [NUM_CH*COLOR_W-1:0] w_col_pack;

  assign w_nsync = vbus.nVDSYNC;
  assign w_vd    = vbus.VD_i;

  always_ff @(posedge VCLK) begin
    if (!nVRST) r_state <= PH_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_nsync)
      w_state_nxt = PH_CAPT;
    else if ((r_state == PH_CAPT) && (r_ph == PH_W'(NUM_CH)))
      w_state_nxt = PH_OVER;
  end

  // Idle (before first sync) and overrun both ignore colour phases until the next sync.
  always_comb begin
    w_cap_sync = !w_nsync;
    w_cap_ch   = w_nsync && (r_state == PH_CAPT) && (r_ph < PH_W'(NUM_CH));
    w_last_ch  = w_cap_ch && (r_ph == PH_W'(NUM_CH - 1));
    w_err      = ((r_state == PH_CAPT) && !w_nsync && (r_ph != '0) && (r_ph < PH_W'(NUM_CH)))
              || ((r_state == PH_CAPT) && w_nsync && (r_ph == PH_W'(NUM_CH)));
  end

  always_comb begin
    w_col_pack = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      w_col_pack[i*COLOR_W +: COLOR_W] = r_ch_sh[i];
  end

  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      r_ph        <= '0;
      r_sync_sh   <= '1;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_phase_err <= 1'b0;
      r_sync_out  <= '1;
      r_col_out   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
        r_ch_sh[i] <= '0;
    end else begin
      r_phase_err <= w_err;
      r_done      <= w_last_ch;
      r_valid     <= r_done;
      // Shadow copy sees the pre-edge values even if a new sync phase lands now.
      if (r_done) begin
        r_sync_out <= r_sync_sh;
        r_col_out  <= w_col_pack;
      end
      if (w_cap_sync) begin
        r_sync_sh <= w_vd[3:0];
        r_ph      <= '0;
      end else if (w_cap_ch) begin
        r_ph <= r_ph + PH_W'(1);
      end
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (w_cap_ch && (r_ph == PH_W'(i)))
          r_ch_sh[i] <= w_vd;
    end
  end

  assign vbus.vdata_valid = r_valid;
  assign vbus.vdata_sync  = r_sync_out;
  assign vbus.vdata_col   = r_col_out;
  assign phase_err        = r_phase_err;

  n64adv_vmode_detect #(
    .LINE_W     (LINE_W),
    .PAL_THRESH (PAL_THRESH)
  ) u_vmode_detect (
    .VCLK          (VCLK),
    .nVRST         (nVRST),
    .i_valid       (r_valid),
    .i_nvsync      (r_sync_out[SYNC_VSYNC]),
    .i_nhsync      (r_sync_out[SYNC_HSYNC]),
    .o_lines_field (lines_field),
    .o_is_pal      (is_pal),
    .o_is_480i     (is_480i),
    .o_field_id    (field_id)
  );

endmodule

// File: tb/tb_n64adv_vdemux_gen.sv
// Directed bench for n64adv_vdemux_gen: 3-channel/7-bit and 2-channel/8-bit builds,
// pixel scoreboard, framing errors and PAL/NTSC/interlace detection.
module tb_n64adv_vdemux_gen;

  logic clk = 1'b0;
  logic nVRST = 1'b0;
  always #5 clk = ~clk;

  n64adv_vdemux_gen_if #(.COLOR_W(7), .NUM_CH(3)) vif3 ();
  n64adv_vdemux_gen_if #(.COLOR_W(8), .NUM_CH(2)) vif2 ();

  logic       err3, pal3, i480_3, fid3;
  logic [9:0] lf3;
  logic       err2, pal2, i480_2, fid2;
  logic [9:0] lf2;

  n64adv_vdemux_gen #(.COLOR_W(7), .NUM_CH(3), .LINE_W(10), .PAL_THRESH(300)) dut3 (
    .VCLK(clk), .nVRST(nVRST), .vbus(vif3), .phase_err(err3),
    .lines_field(lf3), .is_pal(pal3), .is_480i(i480_3), .field_id(fid3)
  );

  n64adv_vdemux_gen #(.COLOR_W(8), .NUM_CH(2), .LINE_W(10), .PAL_THRESH(300)) dut2 (
    .VCLK(clk), .nVRST(nVRST), .vbus(vif2), .phase_err(err2),
    .lines_field(lf2), .is_pal(pal2), .is_480i(i480_2), .field_id(fid2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt3 = 0, val_cnt3 = 0, err_cnt2 = 0;
  int gap3 = 0, last3 = -1, gap2 = 0, last2 = -1;
  logic [24:0] q3[$];
  logic [19:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (err3) err_cnt3++;
    if (err2) err_cnt2++;
    if (vif3.vdata_valid) begin
      val_cnt3++;
      chk("valid3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) chk("pixel3", 32'({vif3.vdata_sync, vif3.vdata_col}), 32'(q3.pop_front()));
      if (gap3 != 0 && last3 >= 0) chk("gap3", 32'(cyc - last3), 32'(gap3));
      last3 = cyc;
    end
    if (vif2.vdata_valid) begin
      chk("valid2_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) chk("pixel2", 32'({vif2.vdata_sync, vif2.vdata_col}), 32'(q2.pop_front()));
      if (gap2 != 0 && last2 >= 0) chk("gap2", 32'(cyc - last2), 32'(gap2));
      last2 = cyc;
    end
  end

  task automatic d3(input logic ns, input logic [6:0] d);
    vif3.nVDSYNC = ns;
    vif3.VD_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pix3(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    d3(1'b0, {3'b000, s});
    d3(1'b1, r);
    d3(1'b1, g);
    d3(1'b1, b);
    q3.push_back({s, b, g, r});
  endtask

  task automatic pix3r(input logic [3:0] s);
    pix3(s, 7'($urandom), 7'($urandom), 7'($urandom));
  endtask

  task automatic vs3(input logic fid);
    pix3r({1'b0, 1'b1, fid, 1'b1});
  endtask

  task automatic lines3(input int n);
    pix3r(4'hF);
    for (int i = 0; i < n; i++) begin
      pix3r(4'hD);
      pix3r(4'hF);
    end
  endtask

  task automatic d2(input logic ns, input logic [7:0] d);
    vif2.nVDSYNC = ns;
    vif2.VD_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pix2(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    d2(1'b0, {4'h0, s});
    d2(1'b1, a);
    d2(1'b1, b);
    q2.push_back({s, b, a});
  endtask

  initial begin
    int e0, v0;
    vif3.nVDSYNC = 1'b1; vif3.VD_i = '0;
    vif2.nVDSYNC = 1'b1; vif2.VD_i = '0;
    repeat (3) @(posedge clk);
    #1;
    nVRST = 1'b1;

    chk("rst_valid", 32'(vif3.vdata_valid), 32'd0);
    chk("rst_sync", 32'(vif3.vdata_sync), 32'hF);
    chk("rst_col", 32'(vif3.vdata_col), 32'd0);
    chk("rst_err", 32'(err3), 32'd0);
    chk("rst_lines", 32'(lf3), 32'd0);
    chk("rst_mode", 32'({pal3, i480_3, fid3}), 32'd0);
    chk("rst_sync2", 32'(vif2.vdata_sync), 32'hF);

    // Reset held 3 cycles in the middle of a pixel.
    d3(1'b0, 7'h0F); d3(1'b1, 7'h11); d3(1'b1, 7'h22);
    nVRST = 1'b0;
    d3(1'b1, 7'h33); d3(1'b1, 7'h44); d3(1'b1, 7'h55);
    nVRST = 1'b1;
    d3(1'b1, 7'h66); d3(1'b1, 7'h77);
    chk("midrst_valid", 32'(vif3.vdata_valid), 32'd0);
    chk("midrst_sync", 32'(vif3.vdata_sync), 32'hF);
    chk("midrst_nvalid", 32'(val_cnt3), 32'd0);
    chk("midrst_nerr", 32'(err_cnt3), 32'd0);

    // Back-to-back pixels: one strobe every 4 VCLK.
    gap3 = 4; last3 = -1;
    pix3(4'hF, 7'h11, 7'h22, 7'h33);
    pix3(4'hE, 7'h7F, 7'h00, 7'h55);
    pix3(4'hA, 7'h01, 7'h40, 7'h2A);
    pix3(4'hB, 7'h3C, 7'h5A, 7'h66);
    pix3(4'hF, 7'h12, 7'h34, 7'h56);
    d3(1'b0, 7'h0F);
    gap3 = 0;
    d3(1'b0, 7'h0F);
    chk("first_col", 32'(val_cnt3), 32'd5);
    chk("stream_err", 32'(err_cnt3), 32'd0);

    // Short frame: only 2 colour phases before the next sync.
    e0 = err_cnt3; v0 = val_cnt3;
    d3(1'b0, 7'h0F); d3(1'b1, 7'h10); d3(1'b1, 7'h20);
    pix3(4'hF, 7'h21, 7'h43, 7'h65);
    d3(1'b0, 7'h0F); d3(1'b0, 7'h0F);
    chk("short_err", 32'(err_cnt3 - e0), 32'd1);
    chk("short_valid", 32'(val_cnt3 - v0), 32'd1);

    // Long frame: 5 colour phases; the first three still form a pixel.
    e0 = err_cnt3; v0 = val_cnt3;
    d3(1'b0, 7'h0F); d3(1'b1, 7'h01); d3(1'b1, 7'h02); d3(1'b1, 7'h03);
    q3.push_back({4'hF, 7'h03, 7'h02, 7'h01});
    d3(1'b1, 7'h04); d3(1'b1, 7'h05);
    repeat (3) d3(1'b1, 7'h7F);
    chk("long_err", 32'(err_cnt3 - e0), 32'd1);
    chk("long_valid", 32'(val_cnt3 - v0), 32'd1);
    pix3(4'hF, 7'h0A, 7'h0B, 7'h0C);
    d3(1'b0, 7'h0F); d3(1'b0, 7'h0F);
    chk("long_recover", 32'(val_cnt3 - v0), 32'd2);
    chk("long_q", 32'(q3.size()), 32'd0);

    // 312-line fields, constant field id (coincident hsync/vsync falls).
    vs3(1'b0); lines3(312);
    vs3(1'b0); lines3(312);
    vs3(1'b0); lines3(312);
    vs3(1'b1);
    d3(1'b0, 7'h0F); d3(1'b0, 7'h0F);
    chk("pal_lines", 32'(lf3), 32'd312);
    chk("pal_is_pal", 32'(pal3), 32'd1);
    chk("pal_is_480i", 32'(i480_3), 32'd0);
    chk("pal_fid", 32'(fid3), 32'd1);

    // 263-line fields, alternating field id.
    lines3(263); vs3(1'b0);
    lines3(263); vs3(1'b1);
    lines3(263); vs3(1'b0);
    d3(1'b0, 7'h0F); d3(1'b0, 7'h0F);
    chk("ntsc_lines", 32'(lf3), 32'd263);
    chk("ntsc_is_pal", 32'(pal3), 32'd0);
    chk("ntsc_is_480i", 32'(i480_3), 32'd1);
    chk("ntsc_fid", 32'(fid3), 32'd0);

    // Line counter saturates; a single equal-field pair keeps 480i.
    lines3(1030); vs3(1'b0);
    d3(1'b0, 7'h0F); d3(1'b0, 7'h0F);
    chk("sat_lines", 32'(lf3), 32'd1023);
    chk("sat_is_pal", 32'(pal3), 32'd1);
    chk("hyst_hold_480i", 32'(i480_3), 32'd1);
    chk("fields_q", 32'(q3.size()), 32'd0);

    // Two-channel, 8-bit build: strobe every 3 VCLK.
    gap2 = 3; last2 = -1;
    pix2(4'hF, 8'hA5, 8'h5A);
    pix2(4'hE, 8'h01, 8'hFF);
    pix2(4'h7, 8'h80, 8'h7E);
    pix2(4'hD, 8'h3C, 8'hC3);
    pix2(4'hF, 8'h12, 8'h34);
    d2(1'b0, 8'h0F);
    gap2 = 0;
    d2(1'b0, 8'h0F);
    chk("nc2_q", 32'(q2.size()), 32'd0);
    chk("nc2_err", 32'(err_cnt2), 32'd0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
